// File: rtl/pipeline_retire_tracer_if.sv
// Retirement record stream from the WISC trace source to a pipeline-trace consumer.
// The master presents the FIFO head; the slave accepts it with ret_ready.
interface pipeline_retire_tracer_if #(
  parameter int TAG_W   = 8,
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               ret_valid;
  logic               ret_ready;
  logic [TAG_W-1:0]   ret_tag;
  logic [PC_W-1:0]    ret_pc;
  logic [INSTR_W-1:0] ret_instr;
  logic [3:0]         ret_stalls;
  logic [7:0]         ret_cycles;

  modport master (
    output ret_valid, ret_tag, ret_pc, ret_instr, ret_stalls, ret_cycles,
    input  ret_ready
  );

  modport slave (
    input  ret_valid, ret_tag, ret_pc, ret_instr, ret_stalls, ret_cycles,
    output ret_ready
  );
endinterface

// File: rtl/pipeline_retire_tracer.sv
// Tags instructions leaving IF, shadows them through ID/EX/MEM/WB with the
// datapath's stall/flush rules, and queues a retirement record per WB retirement.
module pipeline_retire_tracer #(
  parameter int TAG_W      = 8,
  parameter int PC_W       = 16,
  parameter int INSTR_W    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_valid,
  input  logic [PC_W-1:0]          if_pc,
  input  logic [INSTR_W-1:0]       if_instr,
  input  logic                     stall,
  input  logic                     flush,
  pipeline_retire_tracer_if.master ret,
  output logic                     overflow,
  output logic [15:0]              retired_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [7:0]         entry_cyc;
    logic [3:0]         stalls;
  } slot_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         stalls;
    logic [7:0]         cycles;
  } rec_t;

  logic [15:0]      cyc_q, cyc_d;
  logic [TAG_W-1:0] next_tag_q, next_tag_d;
  slot_t            id_q, id_d;
  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  slot_t            wb_q, wb_d;

  rec_t             fifo_q [FIFO_DEPTH];
  rec_t             fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      retired_q, retired_d;

  logic             push;
  logic             pop;
  logic             full;
  logic             accept;
  rec_t             wb_rec;

  // Shadow pipeline: a stall freezes ID and injects a bubble into EX; flush only matters unstalled.
  always_comb begin
    cyc_d      = cyc_q + 16'd1;
    next_tag_d = next_tag_q;
    id_d       = id_q;
    ex_d       = id_q;
    mem_d      = ex_q;
    wb_d       = mem_q;

    if (stall) begin
      ex_d = '0;
      if (id_q.valid && (id_q.stalls != 4'hF)) begin
        id_d.stalls = id_q.stalls + 4'd1;
      end
    end else if (!flush && if_valid) begin
      id_d.valid     = 1'b1;
      id_d.tag       = next_tag_q;
      id_d.pc        = if_pc;
      id_d.instr     = if_instr;
      id_d.entry_cyc = cyc_q[7:0];
      id_d.stalls    = 4'd0;
      next_tag_d     = next_tag_q + TAG_W'(1);
    end else begin
      id_d = '0;
    end
  end

  // A push into a full FIFO survives only when the head leaves on the same edge.
  always_comb begin
    push   = wb_q.valid;
    pop    = (count_q != '0) && ret.ret_ready;
    full   = (count_q == CNT_W'(FIFO_DEPTH));
    accept = push && (!full || pop);

    wb_rec.tag    = wb_q.tag;
    wb_rec.pc     = wb_q.pc;
    wb_rec.instr  = wb_q.instr;
    wb_rec.stalls = wb_q.stalls;
    wb_rec.cycles = cyc_q[7:0] - wb_q.entry_cyc;

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (accept) begin
      fifo_d[wr_ptr_q] = wb_rec;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q | (push && full && !pop);
    retired_d  = retired_q + 16'(push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q      <= '0;
      next_tag_q <= '0;
      id_q       <= '0;
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      cyc_q      <= cyc_d;
      next_tag_q <= next_tag_d;
      id_q       <= id_d;
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      retired_q  <= retired_d;
    end
  end

  // Head is presented straight from registers, so ret_ready never reaches an output.
  assign ret.ret_valid  = (count_q != '0);
  assign ret.ret_tag    = fifo_q[rd_ptr_q].tag;
  assign ret.ret_pc     = fifo_q[rd_ptr_q].pc;
  assign ret.ret_instr  = fifo_q[rd_ptr_q].instr;
  assign ret.ret_stalls = fifo_q[rd_ptr_q].stalls;
  assign ret.ret_cycles = fifo_q[rd_ptr_q].cycles;

  assign overflow      = overflow_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_pipeline_retire_tracer.sv
// Scenario and randomized checks of pipeline_retire_tracer against an
// edge-count model: each instruction's push edge and record are computed from when it enters/leaves ID.
module tb_pipeline_retire_tracer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [15:0] if_pc = '0;
  logic [15:0] if_instr = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        overflow;
  logic [15:0] retired_count;

  pipeline_retire_tracer_if #(.TAG_W(8), .PC_W(16), .INSTR_W(16)) rif ();

  pipeline_retire_tracer #(
    .TAG_W(8), .PC_W(16), .INSTR_W(16), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .stall(stall), .flush(flush), .ret(rif.master),
    .overflow(overflow), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tag;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [3:0]  stalls;
    logic [7:0]  cycles;
  } rec_t;

  typedef struct {
    rec_t r;
    int   edge_n;
  } pend_t;

  int vec = 0;
  int miss = 0;

  // Model state: edge index, ID occupant, records waiting to reach WB, FIFO contents.
  int         m_edge;
  logic [7:0] m_tag;
  logic       id_v;
  rec_t       id_r;
  int         id_acc;
  int         m_retired;
  logic       m_ovf;
  pend_t      pend[$];
  rec_t       mq[$];
  rec_t       m_popped[$];
  rec_t       seen[$];

  task automatic model_clear();
    m_edge = 0; m_tag = '0; id_v = 1'b0; id_acc = 0; m_retired = 0; m_ovf = 1'b0;
    pend.delete(); mq.delete(); m_popped.delete(); seen.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    if_valid = 1'b0; stall = 1'b0; flush = 1'b0; rif.ret_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_clear();
  endtask

  // Drives one edge's inputs, advances the model across that edge, returns at the next negedge.
  task automatic step(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                      input logic st, input logic fl, input logic rdy);
    logic  m_pop;
    rec_t  r;
    pend_t p;
    if_valid = v; if_pc = pc; if_instr = ins; stall = st; flush = fl; rif.ret_ready = rdy;
    if (rif.ret_valid && rdy)
      seen.push_back('{rif.ret_tag, rif.ret_pc, rif.ret_instr, rif.ret_stalls, rif.ret_cycles});
    m_pop = (mq.size() != 0) && rdy;
    @(posedge clk);
    if (m_pop) begin
      r = mq.pop_front();
      m_popped.push_back(r);
    end
    if (pend.size() != 0 && pend[0].edge_n == m_edge) begin
      p = pend.pop_front();
      m_retired++;
      if (mq.size() < DEPTH) mq.push_back(p.r);
      else m_ovf = 1'b1;
    end
    if (st) begin
      if (id_v && id_r.stalls != 4'd15) id_r.stalls = id_r.stalls + 4'd1;
    end else begin
      if (id_v) begin
        p.r = id_r;
        p.r.cycles = 8'(m_edge + 3 - id_acc);
        p.edge_n = m_edge + 3;
        pend.push_back(p);
      end
      if (!fl && v) begin
        id_v = 1'b1;
        id_r = '{m_tag, pc, ins, 4'd0, 8'd0};
        id_acc = m_edge;
        m_tag = m_tag + 8'd1;
      end else begin
        id_v = 1'b0;
      end
    end
    m_edge++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vec++; if (rif.ret_valid !== 1'b0) begin miss++; $display("[TB] FAIL reset_valid: got %b want 0", rif.ret_valid); end
    vec++; if (overflow !== 1'b0) begin miss++; $display("[TB] FAIL reset_ovf: got %b want 0", overflow); end
    vec++; if (retired_count !== 16'd0) begin miss++; $display("[TB] FAIL reset_count: got %0d want 0", retired_count); end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      if (i == 0) step(1'b1, 16'h0010, 16'hA123, 1'b0, 1'b0, 1'b1);
      else        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
      vec++;
      if (rif.ret_valid !== (i == 4)) begin
        miss++; $display("[TB] FAIL single_valid_e%0d: got %b want %b", i, rif.ret_valid, (i == 4));
      end
      if (i == 4) begin
        vec++;
        if ({rif.ret_tag, rif.ret_pc, rif.ret_instr, rif.ret_cycles, rif.ret_stalls} !==
            {8'd0, 16'h0010, 16'hA123, 8'd4, 4'd0}) begin
          miss++; $display("[TB] FAIL single_rec: got tag=%0d pc=%h ins=%h cyc=%0d st=%0d want 0/0010/a123/4/0",
                           rif.ret_tag, rif.ret_pc, rif.ret_instr, rif.ret_cycles, rif.ret_stalls);
        end
      end
    end
    vec++; if (retired_count !== 16'd1) begin miss++; $display("[TB] FAIL single_count: got %0d want 1", retired_count); end
  endtask

  task automatic test_stall();
    do_reset();
    step(1'b1, 16'h0100, 16'h1111, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0102, 16'h2222, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0104, 16'h3333, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h0104, 16'h3333, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h0104, 16'h3333, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    vec++;
    if (seen.size() != 3) begin
      miss++; $display("[TB] FAIL stall_nrec: got %0d want 3", seen.size());
    end else begin
      vec++; if ({seen[0].tag, seen[0].cycles, seen[0].stalls} !== {8'd0, 8'd4, 4'd0}) begin
        miss++; $display("[TB] FAIL stall_rec0: got %0d/%0d/%0d want 0/4/0", seen[0].tag, seen[0].cycles, seen[0].stalls); end
      vec++; if ({seen[1].tag, seen[1].cycles, seen[1].stalls} !== {8'd1, 8'd6, 4'd2}) begin
        miss++; $display("[TB] FAIL stall_rec1: got %0d/%0d/%0d want 1/6/2", seen[1].tag, seen[1].cycles, seen[1].stalls); end
      vec++; if ({seen[2].tag, seen[2].pc, seen[2].cycles, seen[2].stalls} !== {8'd2, 16'h0104, 8'd4, 4'd0}) begin
        miss++; $display("[TB] FAIL stall_rec2: got %0d/%h/%0d/%0d want 2/0104/4/0", seen[2].tag, seen[2].pc, seen[2].cycles, seen[2].stalls); end
    end
    vec++; if (retired_count !== 16'd3) begin miss++; $display("[TB] FAIL stall_count: got %0d want 3", retired_count); end
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b1, 16'h0010, 16'h0A0A, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0020, 16'h0B0B, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h0030, 16'h0C0C, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0040, 16'h0D0D, 1'b1, 1'b1, 1'b1);
    step(1'b1, 16'h0040, 16'h0D0D, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    vec++;
    if (seen.size() != 3) begin
      miss++; $display("[TB] FAIL flush_nrec: got %0d want 3", seen.size());
    end else begin
      vec++; if ({seen[0].tag, seen[0].pc} !== {8'd0, 16'h0010}) begin
        miss++; $display("[TB] FAIL flush_rec0: got %0d/%h want 0/0010", seen[0].tag, seen[0].pc); end
      vec++; if ({seen[1].tag, seen[1].pc, seen[1].stalls, seen[1].cycles} !== {8'd1, 16'h0030, 4'd1, 8'd5}) begin
        miss++; $display("[TB] FAIL flush_rec1: got %0d/%h/%0d/%0d want 1/0030/1/5", seen[1].tag, seen[1].pc, seen[1].stalls, seen[1].cycles); end
      vec++; if ({seen[2].tag, seen[2].pc, seen[2].cycles} !== {8'd2, 16'h0040, 8'd4}) begin
        miss++; $display("[TB] FAIL flush_rec2: got %0d/%h/%0d want 2/0040/4", seen[2].tag, seen[2].pc, seen[2].cycles); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    step(1'b1, 16'h0200, 16'h5A5A, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)  step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    vec++;
    if (seen.size() != 1) begin
      miss++; $display("[TB] FAIL sat_nrec: got %0d want 1", seen.size());
    end else begin
      vec++; if ({seen[0].stalls, seen[0].cycles} !== {4'd15, 8'd24}) begin
        miss++; $display("[TB] FAIL sat_rec: got st=%0d cyc=%0d want 15/24", seen[0].stalls, seen[0].cycles); end
    end
  endtask

  task automatic test_wrap();
    int bad;
    do_reset();
    for (int i = 0; i < 260; i++) step(1'b1, 16'(i), 16'($urandom), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)   step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    vec++; if (seen.size() != 260) begin miss++; $display("[TB] FAIL wrap_nrec: got %0d want 260", seen.size()); end
    bad = 0;
    for (int i = 0; i < seen.size() && i < m_popped.size(); i++) begin
      if (seen[i].tag !== 8'(i) || seen[i] != m_popped[i]) bad++;
    end
    vec++; if (bad != 0) begin miss++; $display("[TB] FAIL wrap_tags: got %0d bad records want 0", bad); end
    vec++; if (retired_count !== 16'd260) begin miss++; $display("[TB] FAIL wrap_count: got %0d want 260", retired_count); end
    vec++; if (overflow !== 1'b0) begin miss++; $display("[TB] FAIL wrap_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++)  step(1'b1, 16'h0300 + 16'(i), 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)  step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    vec++; if (overflow !== 1'b1) begin miss++; $display("[TB] FAIL ovf_flag: got %b want 1", overflow); end
    vec++; if ({rif.ret_valid, rif.ret_tag} !== {1'b1, 8'd0}) begin
      miss++; $display("[TB] FAIL ovf_head: got v=%b tag=%0d want 1/0", rif.ret_valid, rif.ret_tag); end
    for (int i = 0; i < 6; i++)  step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    vec++;
    if (seen.size() != 4) begin
      miss++; $display("[TB] FAIL ovf_nrec: got %0d want 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vec++; if (seen[i].tag !== 8'(i)) begin miss++; $display("[TB] FAIL ovf_drain%0d: got %0d want %0d", i, seen[i].tag, i); end
      end
    end
    vec++; if (rif.ret_valid !== 1'b0) begin miss++; $display("[TB] FAIL ovf_empty: got %b want 0", rif.ret_valid); end
    vec++; if (retired_count !== 16'd6) begin miss++; $display("[TB] FAIL ovf_count: got %0d want 6", retired_count); end

    // Fifth push lands on the edge where the full FIFO is first popped.
    do_reset();
    for (int i = 0; i < 14; i++) step(i < 5, 16'h0400 + 16'(i), 16'h0, 1'b0, 1'b0, i >= 8);
    vec++; if (overflow !== 1'b0) begin miss++; $display("[TB] FAIL fullpp_ovf: got %b want 0", overflow); end
    vec++;
    if (seen.size() != 5) begin
      miss++; $display("[TB] FAIL fullpp_nrec: got %0d want 5", seen.size());
    end else begin
      vec++; if (seen[4].tag !== 8'd4) begin miss++; $display("[TB] FAIL fullpp_tag4: got %0d want 4", seen[4].tag); end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int i = 0; i < 7; i++) step(i < 5, 16'h0500 + 16'(i), 16'h0, 1'b0, 1'b0, 1'b0);
    vec++; if (retired_count !== 16'd3) begin miss++; $display("[TB] FAIL mid_pre: got %0d want 3", retired_count); end
    rst_n = 1'b0;
    #1;
    vec++; if (rif.ret_valid !== 1'b0) begin miss++; $display("[TB] FAIL mid_valid: got %b want 0", rif.ret_valid); end
    vec++; if (retired_count !== 16'd0) begin miss++; $display("[TB] FAIL mid_count: got %0d want 0", retired_count); end
    #1;
    rst_n = 1'b1;
    model_clear();
    step(1'b1, 16'h0077, 16'h7777, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    vec++;
    if (seen.size() != 1) begin
      miss++; $display("[TB] FAIL mid_nrec: got %0d want 1", seen.size());
    end else begin
      vec++; if ({seen[0].tag, seen[0].pc} !== {8'd0, 16'h0077}) begin
        miss++; $display("[TB] FAIL mid_rec: got %0d/%h want 0/0077", seen[0].tag, seen[0].pc); end
    end
  endtask

  task automatic test_random();
    logic v, st, fl, rdy;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 2) != 0) || (i > 480);
      step(v, 16'($urandom), 16'($urandom), st, fl, rdy);
      vec++;
      if (rif.ret_valid !== (mq.size() != 0)) begin
        miss++; $display("[TB] FAIL rnd_valid@%0d: got %b want %b", i, rif.ret_valid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        vec++;
        if ({rif.ret_tag, rif.ret_pc, rif.ret_instr, rif.ret_stalls, rif.ret_cycles} !==
            {mq[0].tag, mq[0].pc, mq[0].instr, mq[0].stalls, mq[0].cycles}) begin
          miss++; $display("[TB] FAIL rnd_head@%0d: got %0d/%h/%h/%0d/%0d want %0d/%h/%h/%0d/%0d", i,
                           rif.ret_tag, rif.ret_pc, rif.ret_instr, rif.ret_stalls, rif.ret_cycles,
                           mq[0].tag, mq[0].pc, mq[0].instr, mq[0].stalls, mq[0].cycles);
        end
      end
      vec++;
      if (retired_count !== 16'(m_retired)) begin
        miss++; $display("[TB] FAIL rnd_count@%0d: got %0d want %0d", i, retired_count, m_retired);
      end
      vec++;
      if (overflow !== m_ovf) begin
        miss++; $display("[TB] FAIL rnd_ovf@%0d: got %b want %b", i, overflow, m_ovf);
      end
    end
  endtask

  initial begin
    rif.ret_ready = 1'b0;
    model_clear();
    $display("[TB] starting pipeline_retire_tracer bench");
    test_reset();
    test_single();
    test_stall();
    test_flush();
    test_saturate();
    test_wrap();
    test_overflow();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/pipeline_retire_tracer.md
# pipeline_retire_tracer

Synthesizable trace source for the 5-stage WISC CPU. It watches the IF stage and the pipeline's stall and flush controls, and tags each instruction that leaves IF with a sequence number. It carries each tag through shadow ID/EX/MEM/WB slots with the same advance, stall and flush rules as the datapath. When an instruction reaches WB, it pushes a retirement record into a small FIFO, which a pipeline-trace consumer drains over a valid/ready handshake.

## Interface
Parameters:
- TAG_W, 8, sequence-tag width; tags wrap modulo 2^TAG_W
- PC_W, 16, PC width
- INSTR_W, 16, instruction width
- FIFO_DEPTH, 4, retirement FIFO entries; power of two, ≥2

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  a real (non-bubble) instruction occupies IF this cycle
- if_pc  in  PC_W  PC of the IF instruction
- if_instr  in  INSTR_W  IF instruction word
- stall  in  1  hold IF and ID; bubble inserted into EX
- flush  in  1  squash the IF instruction; a bubble enters ID
- ret_valid  out  1  FIFO head holds a record
- ret_ready  in  1  consumer accepts the head this cycle
- ret_tag  out  TAG_W  head record tag
- ret_pc  out  PC_W  head record PC
- ret_instr  out  INSTR_W  head record instruction
- ret_stalls  out  4  stall cycles the record spent in ID, saturating at 15
- ret_cycles  out  8  edges from ID entry to FIFO push, mod 256
- overflow  out  1  sticky: a record was dropped because the FIFO was full
- retired_count  out  16  WB retirements since reset, wraps

## Operation
- State:
  - cyc: 16-bit free-running edge counter.
  - next_tag: TAG_W counter.
  - Four slots (ID, EX, MEM, WB), each holding {valid, tag, pc, instr, entry_cyc[7:0], stalls[3:0]}.
  - FIFO: head/tail pointers plus count.
- Every edge, shadow pipeline, evaluated on pre-edge values:
  - stall=1: ID holds and, if valid, increments its stalls (saturating at 15). EX←bubble, MEM←EX, WB←MEM. flush is ignored.
  - stall=0, flush=1: ID←bubble and next_tag is unchanged. EX←ID, MEM←EX, WB←MEM.
  - stall=0, flush=0, if_valid=1: ID←{1, next_tag, if_pc, if_instr, cyc[7:0], 0} and next_tag increments. Others shift.
  - stall=0, flush=0, if_valid=0: ID←bubble. Others shift.
- Retirement, every edge where the WB slot is valid:
  - retired_count increments.
  - A record is pushed: ret_cycles = cyc[7:0] − entry_cyc (mod 256); tag/pc/instr/stalls are copied.
- FIFO:
  - First-word fall-through: ret_* always shows the head; ret_valid = (count≠0). ret_* are undefined when ret_valid=0.
  - Pop happens on an edge with ret_valid & ret_ready.
  - Push while full with no pop: the record is dropped, overflow←1, and FIFO contents are unchanged.
  - Push while full with a simultaneous pop: both are performed, nothing is dropped, and count stays at FIFO_DEPTH.
  - Push and pop while empty cannot coincide, since ret_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow clears only on reset.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - cyc, next_tag, retired_count to 0.
  - All slot valid bits to 0.
  - FIFO count and pointers to 0.
  - overflow to 0.
  - Effect on outputs: ret_valid=0, overflow=0, retired_count=0.
- Reset asserted mid-operation discards all in-flight tags and queued records immediately. The first instruction after release gets tag 0.
- Unstalled latency:
  - Instruction accepted into ID at edge k is in WB after edge k+3.
  - It is pushed at edge k+4, so ret_valid=1 from just after edge k+4.
  - Resulting record: ret_cycles=4, ret_stalls=0.
- Each stall edge spent in ID adds 1 to both ret_cycles and ret_stalls.
- Stall edges while the instruction is still in IF (not yet tagged) count in neither field.
- Handshake: the consumer may hold ret_ready low indefinitely. The head is stable until popped.
- No combinational path from ret_ready to any output.

## Test plan
- Reset, then one instruction with if_valid=1, pc=0x0010, instr=0xA123 at edge 0, then idle, ret_ready=1 → ret_valid rises after edge 4 with tag=0, pc=0x0010, instr=0xA123, ret_cycles=4, ret_stalls=0; retired_count=1.
- Three back-to-back instructions; stall=1 for 2 edges while the second is in ID → records tags 0,1,2 in order; second has ret_stalls=2, ret_cycles=6; third has ret_stalls=0, ret_cycles=4 (it waited in IF); EX bubbles produce no records.
- flush=1 on the edge that would accept pc=0x0020 → no record for 0x0020; the next accepted instruction takes the unused tag; stall=1 with flush=1 on the same edge → flush ignored, ID held.
- 260 continuous instructions, ret_ready=1 → tags 0..255 then 0..3 wrap; retired_count=260; overflow=0.
- ret_ready=0 with 6 instructions retiring → exactly 4 records queued (tags 0–3), overflow=1; then ret_ready=1 → tags 0,1,2,3 drain in order and ret_valid falls; push and pop on the same edge while full → no drop.
- rst_n pulsed low asynchronously mid-stream with 3 records queued and 2 in flight → ret_valid=0 and retired_count=0 immediately; the next instruction retires with tag=0.
